// File: rtl/writeback_result_queue.sv
// rtl/writeback_result_queue.sv - in-order result queue feeding the regfile write port with bypass lookup
module writeback_result_queue #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_mem_valid,
    output logic                       o_mem_ready,
    input  logic [REG_ADDR_W-1:0]      i_mem_rd,
    input  logic [XLEN-1:0]            i_mem_data,
    input  logic                       i_ex_valid,
    output logic                       o_ex_ready,
    input  logic [REG_ADDR_W-1:0]      i_ex_rd,
    input  logic [XLEN-1:0]            i_ex_data,
    input  logic                       i_rf_port_busy,
    output logic                       o_rf_we,
    output logic [REG_ADDR_W-1:0]      o_rf_addr,
    output logic [XLEN-1:0]            o_rf_data,
    input  logic [REG_ADDR_W-1:0]      i_lookup_rs1,
    input  logic [REG_ADDR_W-1:0]      i_lookup_rs2,
    output logic                       o_rs1_hit,
    output logic [XLEN-1:0]            o_rs1_data,
    output logic                       o_rs2_hit,
    output logic [XLEN-1:0]            o_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      valid_q;
    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic                  mem_fire;
    logic                  ex_fire;
    logic [REG_ADDR_W-1:0] push_rd;
    logic [XLEN-1:0]       push_data;
    logic                  push;
    logic                  pop;

    assign o_count = count_q;
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);

    // Readiness is gated by reset so no producer sees a handshake while the queue is held clear.
    assign o_mem_ready = i_rst_n & ~o_full;
    assign o_ex_ready  = i_rst_n & ~o_full & ~i_mem_valid;

    assign mem_fire  = i_mem_valid & o_mem_ready;
    assign ex_fire   = i_ex_valid & o_ex_ready;
    assign push_rd   = mem_fire ? i_mem_rd : i_ex_rd;
    assign push_data = mem_fire ? i_mem_data : i_ex_data;
    // x0 results are acknowledged but dropped; they never occupy a slot.
    assign push      = (mem_fire | ex_fire) & (push_rd != '0);

    assign pop       = ~o_empty & ~i_rf_port_busy;
    assign o_rf_we   = pop;
    assign o_rf_addr = rd_q[head_q];
    assign o_rf_data = data_q[head_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                rd_q[tail_q]    <= push_rd;
                data_q[tail_q]  <= push_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        o_rs1_hit  = 1'b0;
        o_rs1_data = '0;
        o_rs2_hit  = 1'b0;
        o_rs2_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (i_lookup_rs1 != '0) && (rd_q[idx] == i_lookup_rs1)) begin
                o_rs1_hit  = 1'b1;
                o_rs1_data = data_q[idx];
            end
            if (valid_q[idx] && (i_lookup_rs2 != '0) && (rd_q[idx] == i_lookup_rs2)) begin
                o_rs2_hit  = 1'b1;
                o_rs2_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_writeback_result_queue.sv
// tb/tb_writeback_result_queue.sv - directed table, reset corner and randomized model checks
module tb_writeback_result_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_valid, ex_valid, busy;
    logic [AW-1:0]   mem_rd, ex_rd, rs1, rs2;
    logic [XLEN-1:0] mem_data, ex_data;
    logic            mem_ready, ex_ready, rf_we, rs1_hit, rs2_hit, full, empty;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_data, rs1_data, rs2_data;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_result_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .i_ex_valid(ex_valid), .o_ex_ready(ex_ready), .i_ex_rd(ex_rd), .i_ex_data(ex_data),
        .i_rf_port_busy(busy), .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data),
        .i_lookup_rs1(rs1), .i_lookup_rs2(rs2),
        .o_rs1_hit(rs1_hit), .o_rs1_data(rs1_data), .o_rs2_hit(rs2_hit), .o_rs2_data(rs2_data),
        .o_count(count), .o_full(full), .o_empty(empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [31:0] md,
                         input logic ev, input logic [AW-1:0] erd, input logic [31:0] ed,
                         input logic bz, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        ex_valid  = ev; ex_rd  = erd; ex_data  = ed;
        busy = bz; rs1 = r1; rs2 = r2;
    endtask

    typedef struct {
        logic mv; logic [AW-1:0] mrd; logic [31:0] md;
        logic ev; logic [AW-1:0] erd; logic [31:0] ed;
        logic bz; logic [AW-1:0] r1; logic [AW-1:0] r2;
        logic x_mrdy; logic x_erdy; logic x_we; logic [AW-1:0] x_addr; logic [31:0] x_data;
        logic x_h1; logic [31:0] x_d1; logic x_h2; logic [31:0] x_d2; int x_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic mv, logic [AW-1:0] mrd, logic [31:0] md,
        logic ev, logic [AW-1:0] erd, logic [31:0] ed,
        logic bz, logic [AW-1:0] r1, logic [AW-1:0] r2,
        logic x_mrdy, logic x_erdy, logic x_we, logic [AW-1:0] x_addr, logic [31:0] x_data,
        logic x_h1, logic [31:0] x_d1, logic x_h2, logic [31:0] x_d2, int x_cnt);
        vec_t v;
        v.mv = mv; v.mrd = mrd; v.md = md; v.ev = ev; v.erd = erd; v.ed = ed;
        v.bz = bz; v.r1 = r1; v.r2 = r2;
        v.x_mrdy = x_mrdy; v.x_erdy = x_erdy; v.x_we = x_we; v.x_addr = x_addr; v.x_data = x_data;
        v.x_h1 = x_h1; v.x_d1 = x_d1; v.x_h2 = x_h2; v.x_d2 = x_d2; v.x_cnt = x_cnt;
        return v;
    endfunction

    typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } ent_t;
    ent_t model[$];

    initial begin
        rst_n = 1'b0;
        drive(1, 5, 32'h1, 1, 6, 32'h2, 0, 5, 6);
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_ex_ready", ex_ready, 0);
        chk("rst_rs1_hit", rs1_hit, 0);
        chk("rst_rs1_data", rs1_data, 0);
        chk("rst_rs2_hit", rs2_hit, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        //        mv mrd md          ev erd ed        bz r1 r2 | mr er we ad data     h1 d1        h2 d2     cnt
        tbl.push_back(mk(0, 0, 0,        1, 5, 32'h11,   0, 5, 0,  1, 1, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 5, 0,  1, 1, 1, 5, 32'h11,   1, 32'h11,   0, 0,     1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 5, 0,  1, 1, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(1, 3, 32'hAA,   1, 4, 32'hBB,   0, 3, 4,  1, 0, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(0, 0, 0,        1, 4, 32'hBB,   0, 3, 4,  1, 1, 1, 3, 32'hAA,   1, 32'hAA,   0, 0,     1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 3, 4,  1, 1, 1, 4, 32'hBB,   0, 0,        1, 32'hBB, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 3, 4,  1, 1, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(0, 0, 0,        1, 7, 32'h1,    1, 0, 7,  1, 1, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(0, 0, 0,        1, 7, 32'h2,    1, 0, 7,  1, 1, 0, 0, 0,        0, 0,        1, 32'h1, 1));
        tbl.push_back(mk(0, 0, 0,        1, 7, 32'h3,    1, 0, 7,  1, 1, 0, 0, 0,        0, 0,        1, 32'h2, 2));
        tbl.push_back(mk(0, 0, 0,        1, 9, 32'h4,    1, 7, 7,  1, 1, 0, 0, 0,        1, 32'h3,    1, 32'h3, 3));
        tbl.push_back(mk(0, 0, 0,        1, 10, 32'h5,   1, 9, 7,  0, 0, 0, 0, 0,        1, 32'h4,    1, 32'h3, 4));
        tbl.push_back(mk(0, 0, 0,        1, 10, 32'h5,   0, 9, 7,  0, 0, 1, 7, 32'h1,    1, 32'h4,    1, 32'h3, 4));
        tbl.push_back(mk(0, 0, 0,        1, 10, 32'h5,   0, 10, 7, 1, 1, 1, 7, 32'h2,    0, 0,        1, 32'h3, 3));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 10, 7, 1, 1, 1, 7, 32'h3,    1, 32'h5,    1, 32'h3, 3));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 10, 9, 1, 1, 1, 9, 32'h4,    1, 32'h5,    1, 32'h4, 2));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 10, 10, 1, 1, 1, 10, 32'h5,  1, 32'h5,    1, 32'h5, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 10, 0, 1, 1, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(1, 0, 32'hDEAD, 0, 0, 0,        0, 0, 0,  1, 0, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(0, 0, 0,        1, 0, 32'hBEEF, 0, 0, 0,  1, 1, 0, 0, 0,        0, 0,        0, 0,     0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 0, 0,  1, 1, 0, 0, 0,        0, 0,        0, 0,     0));

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].mv, tbl[k].mrd, tbl[k].md, tbl[k].ev, tbl[k].erd, tbl[k].ed,
                  tbl[k].bz, tbl[k].r1, tbl[k].r2);
            #1;
            chk($sformatf("t%0d_mem_ready", k), mem_ready, tbl[k].x_mrdy);
            chk($sformatf("t%0d_ex_ready", k), ex_ready, tbl[k].x_erdy);
            chk($sformatf("t%0d_we", k), rf_we, tbl[k].x_we);
            if (tbl[k].x_we) begin
                chk($sformatf("t%0d_addr", k), rf_addr, tbl[k].x_addr);
                chk($sformatf("t%0d_data", k), rf_data, tbl[k].x_data);
            end
            chk($sformatf("t%0d_rs1_hit", k), rs1_hit, tbl[k].x_h1);
            chk($sformatf("t%0d_rs1_data", k), rs1_data, tbl[k].x_d1);
            chk($sformatf("t%0d_rs2_hit", k), rs2_hit, tbl[k].x_h2);
            chk($sformatf("t%0d_rs2_data", k), rs2_data, tbl[k].x_d2);
            chk($sformatf("t%0d_count", k), count, tbl[k].x_cnt);
            chk($sformatf("t%0d_full", k), full, tbl[k].x_cnt == DEPTH);
            chk($sformatf("t%0d_empty", k), empty, tbl[k].x_cnt == 0);
        end

        // Reset with three results queued: they must vanish without reaching the regfile.
        @(negedge clk); drive(0, 0, 0, 1, 1, 32'h101, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 1, 2, 32'h102, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 1, 3, 32'h103, 1, 0, 0);
        @(negedge clk); drive(1, 4, 32'h104, 0, 0, 0, 1, 2, 0);
        #1;
        chk("r6_count_before", count, 3);
        chk("r6_hit_before", rs1_hit, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("r6_count", count, 0);
        chk("r6_we", rf_we, 0);
        chk("r6_empty", empty, 1);
        chk("r6_mem_ready", mem_ready, 0);
        chk("r6_hit", rs1_hit, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 2, 3);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("r6_no_write", rf_we, 0);
            chk("r6_still_empty", empty, 1);
        end

        // Randomized traffic against a queue model.
        for (int n = 0; n < 3000; n++) begin
            logic mv, ev, bz, exp_mr, exp_er, exp_we, h1, h2;
            logic [AW-1:0] mrd, erd, r1, r2;
            logic [31:0] md, ed, d1, d2;
            @(negedge clk);
            mv  = ($urandom_range(0, 99) < 40);
            ev  = ($urandom_range(0, 99) < 50);
            bz  = ($urandom_range(0, 99) < 35);
            mrd = AW'($urandom_range(0, 7));
            erd = AW'($urandom_range(0, 7));
            r1  = AW'($urandom_range(0, 7));
            r2  = AW'($urandom_range(0, 7));
            md  = $urandom;
            ed  = $urandom;
            drive(mv, mrd, md, ev, erd, ed, bz, r1, r2);
            #1;
            exp_mr = model.size() < DEPTH;
            exp_er = exp_mr && !mv;
            exp_we = model.size() > 0 && !bz;
            h1 = 0; d1 = 0; h2 = 0; d2 = 0;
            for (int j = model.size() - 1; j >= 0; j--) begin
                if (!h1 && r1 != 0 && model[j].rd == r1) begin h1 = 1; d1 = model[j].data; end
                if (!h2 && r2 != 0 && model[j].rd == r2) begin h2 = 1; d2 = model[j].data; end
            end
            chk("rnd_mem_ready", mem_ready, exp_mr);
            chk("rnd_ex_ready", ex_ready, exp_er);
            chk("rnd_we", rf_we, exp_we);
            if (model.size() > 0) begin
                chk("rnd_addr", rf_addr, model[0].rd);
                chk("rnd_data", rf_data, model[0].data);
            end
            chk("rnd_rs1_hit", rs1_hit, h1);
            chk("rnd_rs1_data", rs1_data, d1);
            chk("rnd_rs2_hit", rs2_hit, h2);
            chk("rnd_rs2_data", rs2_data, d2);
            chk("rnd_count", count, model.size());
            if (exp_we) void'(model.pop_front());
            if (mv && exp_mr) begin
                if (mrd != 0) model.push_back('{rd: mrd, data: md});
            end else if (ev && exp_er) begin
                if (erd != 0) model.push_back('{rd: erd, data: ed});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
